// File: rtl/alu_operand_issue_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_issue_pkg
// Shared definitions for the ALU operand-issue stage:
//   - ALUOp encodings understood by the downstream combinational ALU
//   - aluop_legal(): legality test for a 3-bit ALUOp code
//   - issue FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package alu_operand_issue_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [2:0] ALU_ADDU    = 3'b000;
    localparam logic [2:0] ALU_SUBU    = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;
    localparam logic [2:0] ALU_L_RIGHT = 3'b100;
    localparam logic [2:0] ALU_S_RIGHT = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // Legal codes are 000 through 101; 110 and 111 are illegal.
    function automatic logic aluop_legal(input logic [2:0] op);
        return (op <= ALU_S_RIGHT);
    endfunction

endpackage

// File: rtl/alu_operand_issue_grf.sv
// -----------------------------------------------------------------------------
// alu_operand_issue_grf
// General register file: NREG x 32 bits, $0 hardwired to zero.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset (regs -> RST_VAL)
//   rs_addr/rs_data       async read port A
//   rt_addr/rt_data       async read port B
//   dbg_addr/dbg_data     async debug read port
//   we/wa/wd              synchronous write port (writes to $0 ignored)
// -----------------------------------------------------------------------------
module alu_operand_issue_grf
    import alu_operand_issue_pkg::*;
#(
    parameter int              NREG    = 32,
    parameter logic [XLEN-1:0] RST_VAL = 32'h0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs_addr,
    output logic [XLEN-1:0] rs_data,
    input  logic [AW-1:0]   rt_addr,
    output logic [XLEN-1:0] rt_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    // Every GPR needs an asynchronous reset value, so storage is plain flops.
    logic [XLEN-1:0] regs [NREG];

    assign regs[0] = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_q <= RST_VAL;
                end else if (we && (wa == AW'(gi))) begin
                    r_q <= wd;
                end
            end
            assign regs[gi] = r_q;
        end
    endgenerate

    // Addresses beyond NREG read as zero.
    assign rs_data  = (32'(rs_addr)  < NREG) ? regs[rs_addr]  : '0;
    assign rt_data  = (32'(rt_addr)  < NREG) ? regs[rt_addr]  : '0;
    assign dbg_data = (32'(dbg_addr) < NREG) ? regs[dbg_addr] : '0;

endmodule

// File: rtl/alu_operand_issue.sv
// -----------------------------------------------------------------------------
// alu_operand_issue
// Operand-issue stage in front of a combinational ALU. Accepts one request per
// handshake, reads rs/rt (or the immediate) from the GPR file, drives
// registered A/B/ALUOp to the ALU, then writes the ALU result C back to rd on
// the following edge. Illegal ALUOps (110/111) are issued but never written
// back and set the sticky op_err flag.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_rs/rt/rd/op/use_imm/imm       request fields
//   alu_a/alu_b/alu_op (out), alu_c   ALU interface
//   wb_valid/wb_addr/wb_data          write-back observation
//   op_err                            sticky illegal-op flag
//   dbg_addr/dbg_data                 combinational GPR debug read
// Build option: ALU_ISSUE_BYPASS_EN -- accept in EXEC (1 op/cycle) and forward
//   alu_c to operands that depend on the op currently executing.
// -----------------------------------------------------------------------------
module alu_operand_issue
    import alu_operand_issue_pkg::*;
#(
    parameter int              NREG    = 32,
    parameter logic [XLEN-1:0] RST_VAL = 32'h0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs,
    input  logic [AW-1:0]   req_rt,
    input  logic [AW-1:0]   req_rd,
    input  logic [2:0]      req_op,
    input  logic            req_use_imm,
    input  logic [XLEN-1:0] req_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    input  logic [XLEN-1:0] alu_c,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            op_err,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    state_e          state_q;
    logic [AW-1:0]   rd_q;
    logic            legal_q;
    logic [XLEN-1:0] alu_a_q;
    logic [XLEN-1:0] alu_b_q;
    logic [2:0]      alu_op_q;
    logic            op_err_q;

    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] b_d;
    logic            in_exec;
    logic            accept;

    assign in_exec = (state_q == ST_EXEC);

`ifdef ALU_ISSUE_BYPASS_EN
    // The GPR read still returns the pre-write value while the executing op's
    // result sits on alu_c, so dependent operands take it from there.
    logic fwd_ok;
    assign req_ready = 1'b1;
    assign fwd_ok    = in_exec && legal_q && (rd_q != '0);
    assign a_d       = (fwd_ok && (req_rs == rd_q)) ? alu_c : rs_data;
    assign rt_val    = (fwd_ok && !req_use_imm && (req_rt == rd_q)) ? alu_c : rt_data;
`else
    assign req_ready = !in_exec;
    assign a_d       = rs_data;
    assign rt_val    = rt_data;
`endif

    assign accept = req_valid && req_ready;
    assign b_d    = req_use_imm ? req_imm : rt_val;

    assign wb_valid = in_exec && legal_q;
    assign wb_addr  = rd_q;
    assign wb_data  = alu_c;

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign op_err = op_err_q;

    alu_operand_issue_grf #(
        .NREG    (NREG),
        .RST_VAL (RST_VAL)
    ) u_grf (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs_addr  (req_rs),
        .rs_data  (rs_data),
        .rt_addr  (req_rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_valid),
        .wa       (rd_q),
        .wd       (alu_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rd_q     <= '0;
            legal_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 3'b000;
            op_err_q <= 1'b0;
        end else begin
            // Illegal op is flagged at the edge that would have written it back.
            if (in_exec && !legal_q) begin
                op_err_q <= 1'b1;
            end
            if (accept) begin
                alu_a_q  <= a_d;
                alu_b_q  <= b_d;
                alu_op_q <= req_op;
                rd_q     <= req_rd;
                legal_q  <= aluop_legal(req_op);
                state_q  <= ST_EXEC;
            end else begin
                state_q  <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam int EXP_WAIT = 0;
`else
    localparam int EXP_WAIT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [2:0]  req_op;
    logic        req_use_imm;
    logic [31:0] req_imm;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        op_err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t         sb_q[$];
    logic [31:0] m [32];
    int          n_vec = 0;
    int          n_err = 0;
    int          waits;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a >> b[4:0];
            3'd5:    return $signed(a) >>> b[4:0];
            default: return a ^ b;
        endcase
    endfunction

    // Combinational ALU model feeding the DUT.
    assign alu_c = alu_f(alu_op, alu_a, alu_b);

    alu_operand_issue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_op      (req_op),
        .req_use_imm (req_use_imm),
        .req_imm     (req_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .op_err      (op_err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every write-back must match the oldest expected one.
    always @(negedge clk) begin : mon
        wb_t e;
        if (reset_n === 1'b1 && wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_spurious", {31'b0, wb_valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge with
    // req_valid still high.
    task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ui, input logic [31:0] imm);
        logic [31:0] a, b, r;
        logic        legal;
        wb_t         e;
        req_valid   = 1'b1;
        req_op      = op;
        req_rs      = rs;
        req_rt      = rt;
        req_rd      = rd;
        req_use_imm = ui;
        req_imm     = imm;
        waits       = 0;
        while (req_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (req_ready !== 1'b1) chk("ready_timeout", {31'b0, req_ready}, 32'h1);
        a     = m[rs];
        b     = ui ? imm : m[rt];
        r     = alu_f(op, a, b);
        legal = (op <= 3'd5);
        @(posedge clk);
        #1;
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", {29'b0, alu_op}, {29'b0, op});
        if (legal) begin
            e.addr = rd;
            e.data = r;
            sb_q.push_back(e);
            if (rd != 5'd0) m[rd] = r;
        end
        $display("op=%0d rs=%0d rt=%0d rd=%0d imm=%0d:%h a=%h b=%h c=%h waits=%0d",
                 op, rs, rt, rd, ui, imm, a, b, r, waits);
        @(negedge clk);
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, legal});
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic dbg(input logic [4:0] addr);
        dbg_addr = addr;
        #1;
        chk("dbg_reg", dbg_data, m[addr]);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_op", {29'b0, alu_op}, 32'h0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_wb_addr", {27'b0, wb_addr}, 32'h0);
        chk("rst_op_err", {31'b0, op_err}, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        reset_n = 1'b0;
        req_valid = 1'b0; req_rs = '0; req_rt = '0; req_rd = '0;
        req_op = '0; req_use_imm = 1'b0; req_imm = '0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);

        // ADDU $0 + 5 -> r1
        issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5);
        idle();
        dbg(5'd1);
        chk("r1_lit", dbg_data, 32'd5);

        // SUBU 0 - r1 -> r2, then shifts of r2
        issue(3'd1, 5'd0, 5'd1, 5'd2, 1'b0, 32'h0);
        idle();
        dbg(5'd2);
        chk("r2_lit", dbg_data, 32'hFFFF_FFFB);
        issue(3'd5, 5'd2, 5'd0, 5'd3, 1'b1, 32'd1);
        idle();
        dbg(5'd3);
        chk("r3_sra", dbg_data, 32'hFFFF_FFFD);
        issue(3'd4, 5'd2, 5'd0, 5'd3, 1'b1, 32'd1);
        idle();
        dbg(5'd3);
        chk("r3_srl", dbg_data, 32'h7FFF_FFFD);

        // Write to $0: wb pulses with addr 0, $0 stays zero
        issue(3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7);
        idle();
        dbg(5'd0);

        // Illegal op: no write-back, sticky error
        chk("err_before", {31'b0, op_err}, 32'h0);
        issue(3'd6, 5'd1, 5'd1, 5'd4, 1'b0, 32'h0);
        idle();
        chk("err_set", {31'b0, op_err}, 32'h1);
        dbg(5'd4);
        issue(3'd3, 5'd1, 5'd2, 5'd8, 1'b0, 32'h0);
        idle();
        chk("err_sticky", {31'b0, op_err}, 32'h1);
        dbg(5'd8);

        // Four back-to-back requests with req_valid held high
        issue(3'd0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd3);
        chk("burst_wait0", waits, 32'd0);
        issue(3'd0, 5'd5, 5'd0, 5'd6, 1'b1, 32'd4);
        chk("burst_wait1", waits, EXP_WAIT);
        issue(3'd1, 5'd6, 5'd5, 5'd9, 1'b0, 32'h0);
        chk("burst_wait2", waits, EXP_WAIT);
        issue(3'd2, 5'd9, 5'd9, 5'd10, 1'b1, 32'h0000_00FF);
        chk("burst_wait3", waits, EXP_WAIT);
        idle();
        dbg(5'd5);
        dbg(5'd6);
        chk("r6_lit", dbg_data, 32'd7);
        dbg(5'd9);
        dbg(5'd10);

        // Reset during EXEC: everything back to reset values without a clock edge
        issue(3'd0, 5'd0, 5'd0, 5'd7, 1'b1, 32'd9);
        req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        dbg_addr = 5'd7;
        #1;
        chk("rst_r7", dbg_data, 32'h0);
        chk_reset_outputs();
        sb_q.delete();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        @(negedge clk);
        dbg(5'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Recovery after reset
        issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd11);
        idle();
        dbg(5'd1);
        chk("err_cleared", {31'b0, op_err}, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
